// File: rtl/tblink_rpc_cmd_arb.sv
// tblink_rpc_cmd_arb
//   Round-robin arbiter sharing one tblink RPC control command channel among
//   N_REQ requesters. One transaction is outstanding at a time: a single
//   command byte goes to the controller and its response bytes come back to
//   the granted requester. Unsupported command codes (cmd[1:0] = 10/11) are
//   consumed locally and answered with 0xFF without reaching the controller.
//
// Ports
//   clock, reset              : clock, asynchronous active-high reset
//   req_t_dat/valid/ready     : per-requester command target ports (byte k on [8k+7:8k])
//   rsp_i_dat/valid/ready     : per-requester response initiator ports
//   c_i_dat/valid/ready       : command initiator port toward the controller
//   c_t_dat/valid/ready       : response target port from the controller
//   gnt_idx                   : currently (or most recently) granted requester
//   busy                      : a grant is held
module tblink_rpc_cmd_arb #(
    parameter int N_REQ = 2,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [8*N_REQ-1:0]   req_t_dat,
    input  logic [N_REQ-1:0]     req_t_valid,
    output logic [N_REQ-1:0]     req_t_ready,
    output logic [8*N_REQ-1:0]   rsp_i_dat,
    output logic [N_REQ-1:0]     rsp_i_valid,
    input  logic [N_REQ-1:0]     rsp_i_ready,
    output logic [7:0]           c_i_dat,
    output logic                 c_i_valid,
    input  logic                 c_i_ready,
    input  logic [7:0]           c_t_dat,
    input  logic                 c_t_valid,
    output logic                 c_t_ready,
    output logic [IDX_W-1:0]     gnt_idx,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, CMD, RSP, ERR} state_t;

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] gnt_reg, gnt_next;
    logic [IDX_W-1:0] last_reg, last_next;
    logic [1:0]       rem_reg, rem_next;

    logic [7:0]       req_dat_arr [N_REQ];
    logic [7:0]       gnt_dat;
    logic             gnt_valid;
    logic             gnt_rsp_ready;
    logic             cmd_ok;

    logic [IDX_W-1:0] pick;
    logic             any_valid;

    // Output values for the granted requester; fanned out below.
    logic             sel_req_ready;
    logic             sel_rsp_valid;
    logic [7:0]       sel_rsp_dat;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign req_dat_arr[gi] = req_t_dat[8*gi +: 8];
        end
    endgenerate

    assign gnt_dat       = req_dat_arr[gnt_reg];
    assign gnt_valid     = req_t_valid[gnt_reg];
    assign gnt_rsp_ready = rsp_i_ready[gnt_reg];
    assign cmd_ok        = ~gnt_dat[1];   // codes 00 and 01 are forwarded

    // Round-robin search starting one past the last grant. Iterating from the
    // farthest candidate down lets the nearest valid requester win.
    always_comb begin
        pick      = last_reg;
        any_valid = 1'b0;
        for (int i = N_REQ; i >= 1; i--) begin
            if (req_t_valid[(int'(last_reg) + i) % N_REQ]) begin
                pick      = IDX_W'((int'(last_reg) + i) % N_REQ);
                any_valid = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            gnt_reg   <= '0;
            last_reg  <= IDX_W'(N_REQ - 1);
            rem_reg   <= '0;
        end else begin
            state_reg <= state_next;
            gnt_reg   <= gnt_next;
            last_reg  <= last_next;
            rem_reg   <= rem_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        gnt_next   = gnt_reg;
        last_next  = last_reg;
        rem_next   = rem_reg;
        case (state_reg)
            IDLE: begin
                if (any_valid) begin
                    gnt_next   = pick;
                    state_next = CMD;
                end
            end
            CMD: begin
                if (!cmd_ok) begin
                    state_next = ERR;
                end else if (gnt_valid && c_i_ready) begin
                    // sample returns two bytes, advance returns one
                    rem_next   = gnt_dat[0] ? 2'd1 : 2'd2;
                    state_next = RSP;
                end
            end
            RSP: begin
                if (c_t_valid && gnt_rsp_ready) begin
                    rem_next = rem_reg - 2'd1;
                    if (rem_reg == 2'd1) begin
                        last_next  = gnt_reg;
                        state_next = IDLE;
                    end
                end
            end
            ERR: begin
                if (gnt_rsp_ready) begin
                    last_next  = gnt_reg;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        sel_req_ready = 1'b0;
        sel_rsp_valid = 1'b0;
        sel_rsp_dat   = 8'h00;
        c_i_valid     = 1'b0;
        c_i_dat       = 8'h00;
        c_t_ready     = 1'b0;
        case (state_reg)
            CMD: begin
                if (cmd_ok) begin
                    c_i_valid     = gnt_valid;
                    c_i_dat       = gnt_valid ? gnt_dat : 8'h00;
                    sel_req_ready = c_i_ready;
                end else begin
                    // unsupported byte is swallowed here, answered in ERR
                    sel_req_ready = 1'b1;
                end
            end
            RSP: begin
                sel_rsp_valid = c_t_valid;
                sel_rsp_dat   = c_t_valid ? c_t_dat : 8'h00;
                c_t_ready     = gnt_rsp_ready;
            end
            ERR: begin
                sel_rsp_valid = 1'b1;
                sel_rsp_dat   = 8'hFF;
            end
            default: ;
        endcase
    end

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_fanout
            logic is_gnt;
            assign is_gnt                = (gnt_reg == IDX_W'(gi));
            assign req_t_ready[gi]       = is_gnt & sel_req_ready;
            assign rsp_i_valid[gi]       = is_gnt & sel_rsp_valid;
            assign rsp_i_dat[8*gi +: 8]  = is_gnt ? sel_rsp_dat : 8'h00;
        end
    endgenerate

    assign gnt_idx = gnt_reg;
    assign busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_tblink_rpc_cmd_arb.sv
// tb_tblink_rpc_cmd_arb
//   Bench for tblink_rpc_cmd_arb with four requesters. Requesters and the
//   controller are modelled with queues; a transaction-level reference tracks
//   who owns the channel and what is left to deliver, and every cycle's
//   outputs are compared against it. Directed scenarios pin literal results.
module tb_tblink_rpc_cmd_arb;

    localparam int N = 4;
    localparam int IW = 2;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [8*N-1:0]   req_t_dat;
    logic [N-1:0]     req_t_valid;
    logic [N-1:0]     req_t_ready;
    logic [8*N-1:0]   rsp_i_dat;
    logic [N-1:0]     rsp_i_valid;
    logic [N-1:0]     rsp_i_ready;
    logic [7:0]       c_i_dat;
    logic             c_i_valid;
    logic             c_i_ready;
    logic [7:0]       c_t_dat;
    logic             c_t_valid;
    logic             c_t_ready;
    logic [IW-1:0]    gnt_idx;
    logic             busy;

    tblink_rpc_cmd_arb #(.N_REQ(N)) dut (
        .clock(clock), .reset(reset),
        .req_t_dat(req_t_dat), .req_t_valid(req_t_valid), .req_t_ready(req_t_ready),
        .rsp_i_dat(rsp_i_dat), .rsp_i_valid(rsp_i_valid), .rsp_i_ready(rsp_i_ready),
        .c_i_dat(c_i_dat), .c_i_valid(c_i_valid), .c_i_ready(c_i_ready),
        .c_t_dat(c_t_dat), .c_t_valid(c_t_valid), .c_t_ready(c_t_ready),
        .gnt_idx(gnt_idx), .busy(busy)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    // stimulus state
    logic [7:0] cmd_q [N][$];
    logic [7:0] ctl_q [$];
    logic [7:0] sample_q [$];
    logic [7:0] exp_rsp [N][$];
    logic [N-1:0] force0 = '0;
    bit   ct_stray = 1'b0;
    int   ci_pct = 100, ct_pct = 100, rsp_pct = 100;

    // logs
    int grant_log [$];
    int ci_log [$];
    int rsp_log [N][$];
    int req_hs_cnt [N];
    int last_hs_cyc = 0, fall_cyc = 0;
    bit prev_busy = 1'b0;

    // reference state
    int m_owner = -1;
    int m_last  = N - 1;
    int m_gnt   = 0;
    bit m_cmd_done = 1'b0;
    bit m_err = 1'b0;
    int m_left = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endfunction

    function automatic void chk_log(string name, int act[$], int exp[$]);
        n_checks++;
        if (act.size() != exp.size()) begin
            n_err++;
            $display("FAIL %s: got %0d entries expected %0d", name, act.size(), exp.size());
        end else begin
            foreach (exp[i]) begin
                if (act[i] != exp[i]) begin
                    n_err++;
                    $display("FAIL %s: entry %0d got %0h expected %0h", name, i, act[i], exp[i]);
                    break;
                end
            end
        end
    endfunction

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            if (cmd_q[k].size() > 0) begin
                req_t_valid[k] = 1'b1;
                req_t_dat[8*k +: 8] = cmd_q[k][0];
            end else begin
                req_t_valid[k] = 1'b0;
                req_t_dat[8*k +: 8] = 8'h00;
            end
            rsp_i_ready[k] = ($urandom_range(99) < rsp_pct) && !force0[k];
        end
        c_i_ready = ($urandom_range(99) < ci_pct);
        if (ctl_q.size() > 0 && $urandom_range(99) < ct_pct) begin
            c_t_valid = 1'b1;
            c_t_dat   = ctl_q[0];
        end else if (ct_stray) begin
            c_t_valid = 1'b1;
            c_t_dat   = 8'h77;
        end else begin
            c_t_valid = 1'b0;
            c_t_dat   = 8'h00;
        end
    endtask

    initial begin
        req_t_dat = '0; req_t_valid = '0; rsp_i_ready = '0;
        c_i_ready = 1'b0; c_t_dat = '0; c_t_valid = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            drive();
        end
    end

    // Per-cycle reference check and bookkeeping
    always @(negedge clock) begin
        logic [N-1:0]   e_rq, e_rv;
        logic [8*N-1:0] e_rd;
        logic           e_civ, e_ctr;
        logic [7:0]     e_cid, cmd, d;
        int o;
        cyc++;
        if (reset) begin
            m_owner = -1; m_last = N - 1; m_gnt = 0; m_left = 0;
            ctl_q.delete();
            for (int k = 0; k < N; k++) exp_rsp[k].delete();
            prev_busy = 1'b0;
        end
        e_rq = '0; e_rv = '0; e_rd = '0; e_civ = 1'b0; e_cid = 8'h00; e_ctr = 1'b0;
        o = m_owner;
        if (o >= 0) begin
            cmd = req_t_dat[8*o +: 8];
            if (!m_cmd_done) begin
                if (cmd[1:0] < 2'd2) begin
                    e_civ = req_t_valid[o];
                    e_cid = req_t_valid[o] ? cmd : 8'h00;
                    e_rq[o] = c_i_ready;
                end else begin
                    e_rq[o] = 1'b1;
                end
            end else if (m_err) begin
                e_rv[o] = 1'b1;
                e_rd[8*o +: 8] = 8'hFF;
            end else begin
                e_rv[o] = c_t_valid;
                e_rd[8*o +: 8] = c_t_valid ? c_t_dat : 8'h00;
                e_ctr = rsp_i_ready[o];
            end
        end
        chk("req_t_ready", 64'(req_t_ready), 64'(e_rq));
        chk("rsp_i_valid", 64'(rsp_i_valid), 64'(e_rv));
        chk("rsp_i_dat",   64'(rsp_i_dat),   64'(e_rd));
        chk("c_i_valid",   64'(c_i_valid),   64'(e_civ));
        chk("c_i_dat",     64'(c_i_dat),     64'(e_cid));
        chk("c_t_ready",   64'(c_t_ready),   64'(e_ctr));
        chk("busy",        64'(busy),        64'(o >= 0));
        chk("gnt_idx",     64'(gnt_idx),     64'(m_gnt));

        if (!reset) begin
            // controller response byte leaves its queue
            if (c_t_valid && c_t_ready && ctl_q.size() > 0) void'(ctl_q.pop_front());
            for (int k = 0; k < N; k++) begin
                if (req_t_valid[k] && req_t_ready[k] && cmd_q[k].size() > 0) begin
                    cmd = cmd_q[k].pop_front();
                    req_hs_cnt[k]++;
                    if (cmd[1:0] == 2'b00) begin
                        d = (sample_q.size() > 0) ? sample_q.pop_front() : 8'($urandom);
                        ctl_q.push_back(8'h00); ctl_q.push_back(d);
                        exp_rsp[k].push_back(8'h00); exp_rsp[k].push_back(d);
                    end else if (cmd[1:0] == 2'b01) begin
                        ctl_q.push_back(8'h01);
                        exp_rsp[k].push_back(8'h01);
                    end else begin
                        exp_rsp[k].push_back(8'hFF);
                    end
                end
                if (rsp_i_valid[k] && rsp_i_ready[k]) begin
                    rsp_log[k].push_back(int'(rsp_i_dat[8*k +: 8]));
                    last_hs_cyc = cyc;
                    if (exp_rsp[k].size() == 0)
                        chk("rsp_unexpected", 64'(rsp_i_dat[8*k +: 8]), 64'h100);
                    else
                        chk("rsp_byte", 64'(rsp_i_dat[8*k +: 8]), 64'(exp_rsp[k].pop_front()));
                end
            end
            if (c_i_valid && c_i_ready) ci_log.push_back(int'(c_i_dat));
            if (busy && !prev_busy) grant_log.push_back(int'(gnt_idx));
            if (!busy && prev_busy) fall_cyc = cyc;
            prev_busy = busy;

            // advance the reference across the coming edge
            if (m_owner < 0) begin
                for (int i = 1; i <= N; i++) begin
                    if (req_t_valid[(m_last + i) % N]) begin
                        m_owner = (m_last + i) % N;
                        m_gnt = m_owner; m_cmd_done = 1'b0; m_err = 1'b0;
                        break;
                    end
                end
            end else if (!m_cmd_done) begin
                cmd = req_t_dat[8*o +: 8];
                if (cmd[1:0] >= 2'd2) begin
                    m_cmd_done = 1'b1; m_err = 1'b1;
                end else if (req_t_valid[o] && c_i_ready) begin
                    m_cmd_done = 1'b1;
                    m_left = (cmd[1:0] == 2'b00) ? 2 : 1;
                end
            end else if (m_err) begin
                if (rsp_i_ready[o]) begin m_last = o; m_owner = -1; end
            end else if (c_t_valid && rsp_i_ready[o]) begin
                m_left--;
                if (m_left == 0) begin m_last = o; m_owner = -1; end
            end
        end
    end

    task automatic clear_logs();
        grant_log.delete(); ci_log.delete();
        for (int k = 0; k < N; k++) begin rsp_log[k].delete(); req_hs_cnt[k] = 0; end
    endtask

    task automatic wait_idle(int budget);
        int n = 0;
        forever begin
            @(negedge clock); #1;
            if (!busy && ctl_q.size() == 0 && cmd_q[0].size() == 0 && cmd_q[1].size() == 0
                && cmd_q[2].size() == 0 && cmd_q[3].size() == 0) break;
            n++;
            if (n > budget) begin
                chk("wait_idle_timeout", 64'(n), 64'(0));
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clock); #1;
        reset = 1'b1;
        for (int k = 0; k < N; k++) cmd_q[k].delete();
        sample_q.delete();
        force0 = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        clear_logs();
    endtask

    initial begin
        int e[$];
        int n;
        for (int k = 0; k < N; k++) req_hs_cnt[k] = 0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock); #1;
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_gnt", 64'(gnt_idx), 64'(0));
        chk("reset_c_i_valid", 64'(c_i_valid), 64'(0));

        // sample from requester 0
        sample_q.push_back(8'hA5);
        cmd_q[0].push_back(8'h00);
        wait_idle(100);
        e = '{8'h00, 8'hA5}; chk_log("t1_rsp0", rsp_log[0], e);
        e = '{};             chk_log("t1_rsp1", rsp_log[1], e);
        chk("t1_busy_fall", 64'(fall_cyc - last_hs_cyc), 64'(1));

        // two concurrent advance commands
        do_reset();
        cmd_q[0].push_back(8'h0D); cmd_q[1].push_back(8'h0D);
        wait_idle(100);
        e = '{0, 1};           chk_log("t2_grants", grant_log, e);
        e = '{8'h0D, 8'h0D};   chk_log("t2_c_i_dat", ci_log, e);
        e = '{8'h01};          chk_log("t2_rsp0", rsp_log[0], e);
        chk_log("t2_rsp1", rsp_log[1], e);

        // unsupported command from requester 1, answer held until ready
        clear_logs();
        force0[1] = 1'b1;
        cmd_q[1].push_back(8'h02);
        n = 0;
        while (!busy && n < 50) begin @(negedge clock); #1; n++; end
        chk("t3_grant_seen", 64'(busy), 64'(1));
        cmd_q[0].push_back(8'h01); cmd_q[1].push_back(8'h01);
        repeat (6) @(negedge clock);
        #1 force0[1] = 1'b0;
        wait_idle(100);
        e = '{1, 0, 1};        chk_log("t3_grants", grant_log, e);
        e = '{8'h01, 8'h01};   chk_log("t3_c_i_dat", ci_log, e);
        e = '{8'hFF, 8'h01};   chk_log("t3_rsp1", rsp_log[1], e);
        e = '{8'h01};          chk_log("t3_rsp0", rsp_log[0], e);
        chk("t3_req1_accepts", 64'(req_hs_cnt[1]), 64'(2));

        // stray controller response while idle must not be taken
        ct_stray = 1'b1;
        repeat (4) begin @(negedge clock); chk("stray_c_t_ready", 64'(c_t_ready), 64'(0)); end
        #1 ct_stray = 1'b0;
        repeat (2) @(negedge clock);

        // response backpressure
        clear_logs();
        force0[0] = 1'b1;
        sample_q.push_back(8'h3C);
        cmd_q[0].push_back(8'h00);
        n = 0;
        while (!rsp_i_valid[0] && n < 50) begin @(negedge clock); #1; n++; end
        chk("t4_rsp_valid_seen", 64'(rsp_i_valid[0]), 64'(1));
        repeat (5) begin @(negedge clock); chk("t4_c_t_ready_stall", 64'(c_t_ready), 64'(0)); end
        #1 force0[0] = 1'b0;
        wait_idle(100);
        e = '{8'h00, 8'h3C};   chk_log("t4_rsp0", rsp_log[0], e);

        // reset in the middle of a response
        do_reset();
        sample_q.push_back(8'h5A);
        cmd_q[0].push_back(8'h00);
        n = 0;
        while (rsp_log[0].size() < 1 && n < 50) begin @(negedge clock); #1; n++; end
        chk("t5_first_byte", 64'(rsp_log[0].size()), 64'(1));
        force0[0] = 1'b1;
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        chk("t5_rst_busy", 64'(busy), 64'(0));
        chk("t5_rst_rsp_valid", 64'(rsp_i_valid), 64'(0));
        chk("t5_rst_c_t_ready", 64'(c_t_ready), 64'(0));
        chk("t5_rst_gnt", 64'(gnt_idx), 64'(0));
        for (int k = 0; k < N; k++) cmd_q[k].delete();
        sample_q.delete();
        force0 = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        clear_logs();
        cmd_q[1].push_back(8'h01); cmd_q[0].push_back(8'h01);
        wait_idle(100);
        e = '{0, 1};    chk_log("t5_grants", grant_log, e);
        e = '{8'h01};   chk_log("t5_rsp0", rsp_log[0], e);

        // fairness with all four requesters continuously valid
        do_reset();
        for (int k = 0; k < N; k++) begin cmd_q[k].push_back(8'h05); cmd_q[k].push_back(8'h05); end
        wait_idle(200);
        e = '{0, 1, 2, 3, 0, 1, 2, 3}; chk_log("t6_grants", grant_log, e);

        // randomized traffic
        ci_pct = 40 + $urandom_range(60);
        ct_pct = 40 + $urandom_range(60);
        rsp_pct = 40 + $urandom_range(60);
        for (int c = 0; c < 600; c++) begin
            @(negedge clock); #1;
            if ($urandom_range(99) < 30) begin
                int k = $urandom_range(N - 1);
                if (cmd_q[k].size() < 3) cmd_q[k].push_back(8'($urandom));
            end
        end
        ci_pct = 100; ct_pct = 100; rsp_pct = 100;
        wait_idle(2000);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

endmodule
